// File: rtl/simprisc_axil_pkg.sv
// Shared types and constants for the AXI4-Lite unified-memory slave.
// Response codes, write/read FSM state encodings, memory size.
package simprisc_axil_pkg;

  localparam int UMEM_BYTES = 256;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'b00,
    W_HAVE_A = 2'b01,
    W_HAVE_D = 2'b10,
    W_RESP   = 2'b11
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/umem_bank.sv
// Byte-lane memory: one 4-lane write port, two registered write-first read ports.
// Every byte resets to INIT_VAL; read registers reset to zero.
module umem_bank
  import simprisc_axil_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter logic [7:0]  INIT_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [3:0]        wbe_i,
  input  logic [31:0]       wdata_i,
  input  logic              a_en_i,
  input  logic              a_zero_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  output logic [31:0]       a_data_o,
  input  logic              f_en_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic [31:0]       f_data_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(3);

  logic [7:0]        mem_q [DEPTH];
  logic [31:0]       a_data_q;
  logic [31:0]       f_data_q;
  logic [31:0]       a_word;
  logic [31:0]       f_word;
  logic [ADDR_W-1:0] w_base;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] f_base;

  assign w_base = waddr_i  & ~LANE_MASK;
  assign a_base = a_addr_i & ~LANE_MASK;
  assign f_base = f_addr_i & ~LANE_MASK;

  // Same-cycle writes bypass into both read ports lane by lane (write-first).
  always_comb begin
    a_word = '0;
    f_word = '0;
    for (int i = 0; i < 4; i++) begin
      a_word[8*i +: 8] = mem_q[a_base | ADDR_W'(i)];
      f_word[8*i +: 8] = mem_q[f_base | ADDR_W'(i)];
      if (we_i && wbe_i[i] && (w_base == a_base)) a_word[8*i +: 8] = wdata_i[8*i +: 8];
      if (we_i && wbe_i[i] && (w_base == f_base)) f_word[8*i +: 8] = wdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= INIT_VAL;
      a_data_q <= '0;
      f_data_q <= '0;
    end else begin
      if (we_i) begin
        for (int i = 0; i < 4; i++) begin
          if (wbe_i[i]) mem_q[w_base | ADDR_W'(i)] <= wdata_i[8*i +: 8];
        end
      end
      if (a_en_i) a_data_q <= a_zero_i ? 32'h0 : a_word;
      if (f_en_i) f_data_q <= f_word;
    end
  end

  assign a_data_o = a_data_q;
  assign f_data_o = f_data_q;

endmodule

// File: rtl/axil_umem_slave.sv
// AXI4-Lite slave over a 256-byte unified memory plus a never-stalling cpu fetch port.
// Build option AXIL_UMEM_STRB_EN: honour wstrb per byte lane (otherwise all lanes written).
module axil_umem_slave
  import simprisc_axil_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter int         ADDR_W   = 8,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   fetch_addr,
  input  logic                fetch_en,
  output logic [DATA_W-1:0]   fetch_data,
  output logic                fetch_valid
);

  wr_state_t             w_state_q, w_state_d;
  logic [ADDR_W-1:0]     w_addr_q,  w_addr_d;
  logic [DATA_W-1:0]     w_data_q,  w_data_d;
  logic [DATA_W/8-1:0]   w_strb_q,  w_strb_d;
  resp_t                 bresp_q,   bresp_d;
  rd_state_t             r_state_q, r_state_d;
  resp_t                 rresp_q,   rresp_d;
  logic                  fetch_valid_q;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  commit;
  logic [ADDR_W-1:0]     c_addr;
  logic [DATA_W-1:0]     c_data;
  logic [DATA_W/8-1:0]   c_strb;
  logic                  bank_we;
  logic [3:0]            bank_be;

  assign awready = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_D);
  assign wready  = (w_state_q == W_IDLE) || (w_state_q == W_HAVE_A);
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;
  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rresp   = rresp_q;
  assign fetch_valid = fetch_valid_q;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid  && wready;
  assign ar_hs = arvalid && arready;

  // The commit takes whichever half arrives this cycle and the latched copy of the other.
  always_comb begin
    w_state_d = w_state_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    c_addr    = awaddr;
    c_data    = wdata;
    c_strb    = wstrb;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end else if (aw_hs) begin
          w_addr_d  = awaddr;
          w_state_d = W_HAVE_A;
        end else if (w_hs) begin
          w_data_d  = wdata;
          w_strb_d  = wstrb;
          w_state_d = W_HAVE_D;
        end
      end
      W_HAVE_A: begin
        c_addr = w_addr_q;
        if (w_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_HAVE_D: begin
        c_data = w_data_q;
        c_strb = w_strb_q;
        if (aw_hs) begin
          commit    = 1'b1;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    if (commit) bresp_d = is_aligned(c_addr[1:0]) ? OKAY : SLVERR;
  end

  assign bank_we = commit && is_aligned(c_addr[1:0]);

`ifdef AXIL_UMEM_STRB_EN
  assign bank_be = c_strb;
`else
  // Strobes are don't-care here; the OR keeps them referenced without affecting the lanes.
  assign bank_be = c_strb | 4'hF;
`endif

  always_comb begin
    r_state_d = r_state_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          r_state_d = R_DATA;
          rresp_d   = is_aligned(araddr[1:0]) ? OKAY : SLVERR;
        end
      end
      R_DATA: begin
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q     <= W_IDLE;
      w_addr_q      <= '0;
      w_data_q      <= '0;
      w_strb_q      <= '0;
      bresp_q       <= OKAY;
      r_state_q     <= R_IDLE;
      rresp_q       <= OKAY;
      fetch_valid_q <= 1'b0;
    end else begin
      w_state_q     <= w_state_d;
      w_addr_q      <= w_addr_d;
      w_data_q      <= w_data_d;
      w_strb_q      <= w_strb_d;
      bresp_q       <= bresp_d;
      r_state_q     <= r_state_d;
      rresp_q       <= rresp_d;
      fetch_valid_q <= fetch_en;
    end
  end

  umem_bank #(
    .ADDR_W   (ADDR_W),
    .INIT_VAL (INIT_VAL)
  ) u_bank (
    .clk      (clk),
    .rst      (reset),
    .we_i     (bank_we),
    .waddr_i  (c_addr),
    .wbe_i    (bank_be),
    .wdata_i  (c_data),
    .a_en_i   (ar_hs),
    .a_zero_i (!is_aligned(araddr[1:0])),
    .a_addr_i (araddr),
    .a_data_o (rdata),
    .f_en_i   (fetch_en),
    .f_addr_i (fetch_addr),
    .f_data_o (fetch_data)
  );

endmodule

// File: tb/tb_axil_umem_slave.sv
// Directed bench for axil_umem_slave: vector table of write/read pairs plus handshake corner sequences.
module tb_axil_umem_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [7:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [7:0]  fetch_addr;
  logic        fetch_en;
  logic [31:0] fetch_data;
  logic        fetch_valid;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axil_umem_slave dut (
    .clk(clk), .reset(reset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .fetch_addr(fetch_addr), .fetch_en(fetch_en),
    .fetch_data(fetch_data), .fetch_valid(fetch_valid)
  );

  typedef struct {
    logic        do_wr;
    logic [7:0]  waddr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    logic [1:0]  exp_bresp;
    logic [7:0]  raddr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

`ifdef AXIL_UMEM_STRB_EN
  localparam logic [31:0] EXP_PARTIAL = 32'h11BB33DD;
  localparam logic [31:0] EXP_NOSTRB  = 32'h0000_0000;
`else
  localparam logic [31:0] EXP_PARTIAL = 32'hAABBCCDD;
  localparam logic [31:0] EXP_NOSTRB  = 32'h1234_5678;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_both(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] exp_resp);
    chk("awready_before_wr", 32'(awready), 32'd1);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_after_hs", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("bvalid_cleared", 32'(bvalid), 32'd0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    araddr = a; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("rvalid_after_ar", 32'(rvalid), 32'd1);
    chk("rdata", rdata, exp_d);
    chk("rresp", 32'(rresp), 32'(exp_r));
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("rvalid_cleared", 32'(rvalid), 32'd0);
  endtask

  task automatic fetch(input logic [7:0] a, input logic [31:0] exp_d);
    fetch_addr = a; fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("fetch_valid", 32'(fetch_valid), 32'd1);
    chk("fetch_data", fetch_data, exp_d);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 8'h00, 32'hB4B4B4B4, 4'hF, 2'b00, 8'h00, 32'hB4B4B4B4, 2'b00};
    vecs[1] = '{1'b1, 8'h04, 32'h11223344, 4'hF, 2'b00, 8'h04, 32'h11223344, 2'b00};
    vecs[2] = '{1'b1, 8'h02, 32'hDEADBEEF, 4'hF, 2'b10, 8'h00, 32'hB4B4B4B4, 2'b00};
    vecs[3] = '{1'b1, 8'h04, 32'hAABBCCDD, 4'b0101, 2'b00, 8'h04, EXP_PARTIAL, 2'b00};
    vecs[4] = '{1'b1, 8'hFC, 32'hCAFEF00D, 4'hF, 2'b00, 8'hFC, 32'hCAFEF00D, 2'b00};
    vecs[5] = '{1'b0, 8'h00, 32'h0,        4'h0, 2'b00, 8'h03, 32'h0,        2'b10};
    vecs[6] = '{1'b1, 8'h08, 32'h12345678, 4'h0, 2'b00, 8'h08, EXP_NOSTRB,  2'b00};

    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0; fetch_addr = '0; fetch_en = 1'b0;
    tick();
    tick();
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_bresp", 32'(bresp), 32'd0);
    chk("rst_rresp", 32'(rresp), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_fetch_data", fetch_data, 32'd0);
    chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_wr) wr_both(vecs[i].waddr, vecs[i].wdat, vecs[i].strb, vecs[i].exp_bresp);
      rd(vecs[i].raddr, vecs[i].exp_rdata, vecs[i].exp_rresp);
    end
    fetch(8'h00, 32'hB4B4B4B4);

    // W leads AW by three cycles
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("wlead_wready_low", 32'(wready), 32'd0);
    chk("wlead_awready_high", 32'(awready), 32'd1);
    tick();
    tick();
    chk("wlead_wready_still_low", 32'(wready), 32'd0);
    chk("wlead_no_bvalid", 32'(bvalid), 32'd0);
    awaddr = 8'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("wlead_bvalid", 32'(bvalid), 32'd1);
    chk("wlead_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("wlead_bvalid_drop", 32'(bvalid), 32'd0);
    tick();
    chk("wlead_single_resp", 32'(bvalid), 32'd0);
    fetch(8'h10, 32'h12345678);
    fetch(8'h12, 32'h12345678);

    // B channel stalled for five cycles with a new AW/W waiting
    awaddr = 8'h20; wdata = 32'h5555AAAA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awaddr = 8'h24; wdata = 32'h77777777;
    for (int c = 0; c < 5; c++) begin
      chk("stall_bvalid", 32'(bvalid), 32'd1);
      chk("stall_bresp", 32'(bresp), 32'd0);
      chk("stall_awready", 32'(awready), 32'd0);
      chk("stall_wready", 32'(wready), 32'd0);
      tick();
    end
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("stall_release_bvalid", 32'(bvalid), 32'd0);
    chk("stall_release_awready", 32'(awready), 32'd1);
    chk("stall_release_wready", 32'(wready), 32'd1);
    rd(8'h20, 32'h5555AAAA, 2'b00);
    rd(8'h24, 32'h00000000, 2'b00);

    // Same-cycle write commit, AXI read capture and fetch of one word
    wr_both(8'h30, 32'h01010101, 4'hF, 2'b00);
    awaddr = 8'h30; wdata = 32'h0F0F0F0F; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h30; arvalid = 1'b1; fetch_addr = 8'h31; fetch_en = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; fetch_en = 1'b0;
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_rdata", rdata, 32'h0F0F0F0F);
    chk("coll_fetch", fetch_data, 32'h0F0F0F0F);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;

    // Reset while write holds only an address and a read response is pending
    awaddr = 8'h40; awvalid = 1'b1; araddr = 8'h00; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("pre_rst_awready", 32'(awready), 32'd0);
    chk("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    chk("mid_rst_rvalid", 32'(rvalid), 32'd0);
    chk("mid_rst_awready", 32'(awready), 32'd1);
    chk("mid_rst_arready", 32'(arready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_wready", 32'(wready), 32'd1);
    for (int w = 0; w < 64; w++) begin
      fetch_addr = 8'(w * 4); fetch_en = 1'b1;
      tick();
      chk("post_rst_word", fetch_data, 32'h0);
    end
    fetch_en = 1'b0;
    rd(8'hFC, 32'h00000000, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
